// File: rtl/bank_readback.sv
// Serializes a captured parameter bank into pipe words for okPipeOut readback, word 0 first.
// Optional READBACK_CHECKSUM_EN appends a mod-2^WORD_W sum of all data words as a final word.
module bank_readback #(
   parameter int unsigned WORD_W    = 16,
   parameter int unsigned NUM_WORDS = 64,
   parameter int unsigned ADDR_W    = 6
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        snapshot,
   input  logic [WORD_W*NUM_WORDS-1:0] bank_in,
   input  logic                        ep_read,
   output logic [WORD_W-1:0]           ep_datain,
   output logic                        busy,
   output logic                        done,
   output logic [ADDR_W:0]             word_count,
   output logic                        underrun
);

   localparam int unsigned BANK_W = WORD_W * NUM_WORDS;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_WORDS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef READBACK_CHECKSUM_EN
   localparam logic [1:0] ST_CHECK = 2'd2;
`endif

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [BANK_W-1:0] shadow;
   logic [BANK_W-1:0] shadow_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [ADDR_W-1:0] ptr_inc;
   logic [CNT_W-1:0]  count_nxt;
   logic [WORD_W-1:0] data_nxt;
   logic              busy_nxt;
   logic              done_nxt;
   logic              underrun_nxt;

   // Word view of the shadow copy so the pointer selects a whole word
   logic [WORD_W-1:0] words [NUM_WORDS];

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_words
      assign words[g] = shadow[g*WORD_W +: WORD_W];
   end

   assign ptr_inc = ptr + ADDR_W'(1);

`ifdef READBACK_CHECKSUM_EN
   logic [WORD_W-1:0] sum;
   logic [WORD_W-1:0] sum_nxt;
   logic [WORD_W-1:0] sum_add;

   assign sum_add = sum + words[ptr];
`endif

   // State register and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         shadow     <= '0;
         ptr        <= '0;
         ep_datain  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
         underrun   <= 1'b0;
`ifdef READBACK_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         state      <= state_nxt;
         shadow     <= shadow_nxt;
         ptr        <= ptr_nxt;
         ep_datain  <= data_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         word_count <= count_nxt;
         underrun   <= underrun_nxt;
`ifdef READBACK_CHECKSUM_EN
         sum        <= sum_nxt;
`endif
      end
   end

   // Next state; snapshot restarts from any state and outranks a same-cycle read
   always_comb begin
      state_nxt    = state;
      shadow_nxt   = shadow;
      ptr_nxt      = ptr;
      count_nxt    = word_count;
      data_nxt     = ep_datain;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      underrun_nxt = underrun;
`ifdef READBACK_CHECKSUM_EN
      sum_nxt      = sum;
`endif

      if (snapshot) begin
         state_nxt    = ST_SEND;
         shadow_nxt   = bank_in;
         ptr_nxt      = '0;
         count_nxt    = '0;
         data_nxt     = bank_in[WORD_W-1:0];
         busy_nxt     = 1'b1;
         underrun_nxt = 1'b0;
`ifdef READBACK_CHECKSUM_EN
         sum_nxt      = '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               data_nxt = '0;
               if (ep_read) begin
                  underrun_nxt = 1'b1;
               end
            end

            ST_SEND: begin
               if (ep_read) begin
                  count_nxt = word_count + CNT_W'(1);
                  if (ptr == LAST_PTR) begin
`ifdef READBACK_CHECKSUM_EN
                     state_nxt = ST_CHECK;
                     data_nxt  = sum_add;
                     sum_nxt   = sum_add;
`else
                     state_nxt = ST_IDLE;
                     data_nxt  = '0;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
`endif
                  end else begin
                     ptr_nxt  = ptr_inc;
                     data_nxt = words[ptr_inc];
`ifdef READBACK_CHECKSUM_EN
                     sum_nxt  = sum_add;
`endif
                  end
               end
            end

`ifdef READBACK_CHECKSUM_EN
            ST_CHECK: begin
               if (ep_read) begin
                  state_nxt = ST_IDLE;
                  count_nxt = word_count + CNT_W'(1);
                  data_nxt  = '0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
`endif

            default: begin
               state_nxt = ST_IDLE;
               data_nxt  = '0;
               busy_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bank_readback.sv
// Bench for bank_readback: directed scenarios plus random traffic against a transfer-queue model.
// Build with READBACK_CHECKSUM_EN to exercise the appended checksum word.
module tb_bank_readback;

   localparam int unsigned WORD_W    = 16;
   localparam int unsigned NUM_WORDS = 64;
   localparam int unsigned ADDR_W    = 6;

   logic                        clk = 1'b0;
   logic                        reset_n;
   logic                        snapshot;
   logic [WORD_W*NUM_WORDS-1:0] bank_in;
   logic                        ep_read;
   logic [WORD_W-1:0]           ep_datain;
   logic                        busy;
   logic                        done;
   logic [ADDR_W:0]             word_count;
   logic                        underrun;

   int total = 0;
   int bad   = 0;

   // Model: the transfer is simply the list of words the host should see, in order
   logic [15:0] bank_m [NUM_WORDS];
   logic [15:0] seq [$];
   int          idx;
   int          m_cnt;
   bit          active;
   bit          m_done;
   bit          m_under;

   bank_readback #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .snapshot   (snapshot),
      .bank_in    (bank_in),
      .ep_read    (ep_read),
      .ep_datain  (ep_datain),
      .busy       (busy),
      .done       (done),
      .word_count (word_count),
      .underrun   (underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bank();
      for (int k = 0; k < NUM_WORDS; k++) bank_in[k*WORD_W +: WORD_W] = bank_m[k];
   endtask

   task automatic model_reset();
      seq.delete();
      idx     = 0;
      m_cnt   = 0;
      active  = 0;
      m_done  = 0;
      m_under = 0;
   endtask

   task automatic model_clock(input bit snap, input bit rd);
      logic [15:0] s;
      m_done = 0;
      if (snap) begin
         seq.delete();
         s = 16'h0000;
         for (int k = 0; k < NUM_WORDS; k++) begin
            seq.push_back(bank_m[k]);
            s = s + bank_m[k];
         end
`ifdef READBACK_CHECKSUM_EN
         seq.push_back(s);
`endif
         idx     = 0;
         m_cnt   = 0;
         active  = 1;
         m_under = 0;
      end else if (rd) begin
         if (active) begin
            idx++;
            m_cnt++;
            if (idx == seq.size()) begin
               active = 0;
               m_done = 1;
            end
         end else begin
            m_under = 1;
         end
      end
   endtask

   task automatic check_outputs();
      logic [15:0] exp_data;
      exp_data = active ? seq[idx] : 16'h0000;
      chk("ep_datain", 32'(ep_datain), 32'(exp_data));
      chk("busy", 32'(busy), 32'(active));
      chk("done", 32'(done), 32'(m_done));
      chk("word_count", 32'(word_count), 32'(m_cnt));
      chk("underrun", 32'(underrun), 32'(m_under));
   endtask

   task automatic cyc(input bit snap, input bit rd);
      snapshot = snap;
      ep_read  = rd;
      @(posedge clk);
      model_clock(snap, rd);
      #1;
      check_outputs();
      snapshot = 1'b0;
      ep_read  = 1'b0;
   endtask

   task automatic tail_read();
`ifdef READBACK_CHECKSUM_EN
      cyc(0, 1);
`endif
   endtask

   initial begin
      logic [WORD_W:0] exp_cnt_full;
      exp_cnt_full = (WORD_W+1)'(NUM_WORDS);
`ifdef READBACK_CHECKSUM_EN
      exp_cnt_full = (WORD_W+1)'(NUM_WORDS + 1);
`endif
      reset_n  = 1'b0;
      snapshot = 1'b0;
      ep_read  = 1'b0;
      bank_in  = '0;
      model_reset();
      #1;
      check_outputs();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;

      // Back-to-back reads of an incrementing bank
      for (int k = 0; k < NUM_WORDS; k++) bank_m[k] = 16'h0100 + 16'(k);
      drive_bank();
      cyc(1, 0);
      chk("first_word", 32'(ep_datain), 32'h0100);
      for (int i = 0; i < NUM_WORDS; i++) begin
         cyc(0, 1);
         if (i < NUM_WORDS - 1) chk("seq_word", 32'(ep_datain), 32'h0100 + 32'(i + 1));
      end
`ifdef READBACK_CHECKSUM_EN
      chk("checksum_inc", 32'(ep_datain), 32'h47E0);
      chk("no_done_at_check", 32'(done), 32'h0);
`endif
      tail_read();
      chk("done_pulse", 32'(done), 32'h1);
      chk("busy_end", 32'(busy), 32'h0);
      chk("count_end", 32'(word_count), 32'(exp_cnt_full));
      cyc(0, 0);
      chk("done_one_cycle", 32'(done), 32'h0);
      chk("count_hold", 32'(word_count), 32'(exp_cnt_full));

      // Sparse reads: same sequence, outputs stable between strobes
      cyc(1, 0);
      for (int i = 0; i < NUM_WORDS; i++) begin
         cyc(0, 0);
         cyc(0, 0);
         cyc(0, 1);
      end
      tail_read();
      cyc(0, 0);

      // Bank changes after snapshot must not leak into the transfer
      cyc(1, 0);
      for (int i = 0; i < 10; i++) cyc(0, 1);
      for (int k = 0; k < NUM_WORDS; k++) bank_m[k] = 16'hA000 + 16'(k);
      drive_bank();
      cyc(0, 0);
      chk("shadow_isolation", 32'(ep_datain), 32'h010A);
      cyc(1, 0);
      chk("resnap_word", 32'(ep_datain), 32'hA000);
      chk("resnap_count", 32'(word_count), 32'h0);

      // Snapshot and read together mid-transfer: snapshot wins
      cyc(0, 1);
      cyc(0, 1);
      cyc(1, 1);
      chk("snap_read_send", 32'(ep_datain), 32'hA000);
      chk("snap_read_cnt", 32'(word_count), 32'h0);

      // Drain, then underrun in idle
      for (int i = 0; i < NUM_WORDS + 2; i++) if (active) cyc(0, 1);
      cyc(0, 1);
      chk("underrun_set", 32'(underrun), 32'h1);
      chk("idle_data", 32'(ep_datain), 32'h0);
      cyc(0, 0);
      chk("underrun_sticky", 32'(underrun), 32'h1);
      cyc(1, 1);
      chk("underrun_clear", 32'(underrun), 32'h0);
      chk("snap_read_idle", 32'(ep_datain), 32'hA000);
      chk("snap_read_idle_cnt", 32'(word_count), 32'h0);

      // Asynchronous reset mid-transfer clears everything without a clock edge
      for (int i = 0; i < 5; i++) cyc(0, 1);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_async_data", 32'(ep_datain), 32'h0);
      chk("rst_async_busy", 32'(busy), 32'h0);
      chk("rst_async_cnt", 32'(word_count), 32'h0);
      @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;
      cyc(0, 0);

`ifdef READBACK_CHECKSUM_EN
      for (int k = 0; k < NUM_WORDS; k++) bank_m[k] = 16'h0001;
      drive_bank();
      cyc(1, 0);
      for (int i = 0; i < NUM_WORDS; i++) cyc(0, 1);
      chk("checksum_ones", 32'(ep_datain), 32'h0040);
      cyc(0, 1);
      chk("checksum_done", 32'(done), 32'h1);
      for (int k = 0; k < NUM_WORDS; k++) bank_m[k] = 16'hFFFF;
      drive_bank();
      cyc(1, 0);
      for (int i = 0; i < NUM_WORDS; i++) cyc(0, 1);
      chk("checksum_wrap", 32'(ep_datain), 32'hFFC0);
      cyc(0, 1);
`endif

      // Random traffic, including one asynchronous reset
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            for (int k = 0; k < NUM_WORDS; k++) bank_m[k] = 16'($urandom);
            drive_bank();
         end
         if (n == 1500) begin
            #3;
            reset_n = 1'b0;
            model_reset();
            @(posedge clk);
            #1;
            check_outputs();
            reset_n = 1'b1;
         end
         cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
